// File: rtl/carpark_log_ctrl.sv
// Circular event log controller for the car-park system: sequences a dual-port
// RAM as a FIFO with pointer wrap, read-latency alignment and overflow policy.
module carpark_log_ctrl #(
  parameter int DEPTH      = 128,
  parameter int AW         = 7,
  parameter int DW         = 40,
  parameter int RD_LATENCY = 1,
  parameter int OVERWRITE  = 0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ev_valid,
  input  logic [DW-1:0] ev_data,
  input  logic          clear,
  input  logic          rd_req,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          ready,
  output logic          ram_wr_enable,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic          ram_rd_enable,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_data,
  input  logic          ram_busy_wr,
  input  logic          ram_busy_rd
);

  localparam int LCW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {INIT, IDLE, RDWAIT} state_t;

  state_t         state_reg, state_next;
  logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]    count_reg, count_next;
  logic           empty_reg, full_reg, overflow_reg, rd_valid_reg;
  logic [DW-1:0]  rd_data_reg;
  logic [LCW-1:0] lat_cnt_reg;

  logic clr_fire, pop_fire, wr_fire, wr_over, ev_drop, rd_done;

  always_comb begin
    ready    = (state_reg != INIT);
    clr_fire = ready && clear;
    // A full log with a same-cycle write would read and write one address;
    // the pop is deferred instead and retries next cycle.
    pop_fire = !reset && !clr_fire && (state_reg == IDLE) && rd_req &&
               !empty_reg && !(full_reg && ev_valid);
    wr_fire  = !reset && !clr_fire && ready && ev_valid &&
               (!full_reg || (OVERWRITE != 0) || pop_fire);
    wr_over  = wr_fire && full_reg && !pop_fire;
    ev_drop  = ev_valid && (!ready || (!clr_fire && full_reg && !wr_fire));
    rd_done  = (state_reg == RDWAIT) && !clr_fire &&
               (lat_cnt_reg == LCW'(RD_LATENCY - 1));

    count_next = count_reg;
    if (clr_fire)
      count_next = '0;
    else if (wr_fire && !pop_fire && !full_reg)
      count_next = count_reg + (AW+1)'(1);
    else if (pop_fire && !wr_fire)
      count_next = count_reg - (AW+1)'(1);

    state_next = state_reg;
    case (state_reg)
      INIT:    if (!ram_busy_wr && !ram_busy_rd) state_next = IDLE;
      IDLE:    if (pop_fire) state_next = RDWAIT;
      RDWAIT:  if (clr_fire || rd_done) state_next = IDLE;
      default: state_next = INIT;
    endcase

    ram_wr_enable = wr_fire;
    ram_wr_addr   = wr_fire ? wr_ptr_reg : '0;
    ram_wr_data   = wr_fire ? ev_data : '0;
    ram_rd_enable = pop_fire;
    ram_rd_addr   = pop_fire ? rd_ptr_reg : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= INIT;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      empty_reg    <= 1'b1;
      full_reg     <= 1'b0;
      overflow_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
      lat_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      empty_reg    <= (count_next == '0);
      full_reg     <= (count_next == (AW+1)'(DEPTH));
      rd_valid_reg <= rd_done;
      if (rd_done)
        rd_data_reg <= ram_rd_data;

      if (clr_fire) begin
        wr_ptr_reg   <= '0;
        rd_ptr_reg   <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (wr_fire)
          wr_ptr_reg <= wr_ptr_reg + AW'(1);
        // Overwriting the oldest entry advances the read side past it.
        if (pop_fire || wr_over)
          rd_ptr_reg <= rd_ptr_reg + AW'(1);
        if (ev_drop)
          overflow_reg <= 1'b1;
      end

      if ((state_reg == RDWAIT) && !rd_done && !clr_fire)
        lat_cnt_reg <= lat_cnt_reg + LCW'(1);
      else
        lat_cnt_reg <= '0;
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign count    = count_reg;
  assign empty    = empty_reg;
  assign full     = full_reg;
  assign overflow = overflow_reg;

endmodule

// File: tb/tb_carpark_log_ctrl.sv
// Bench for carpark_log_ctrl: drop-mode and overwrite-mode instances share one
// stimulus stream, each with its own RAM model and queue-based reference.
module tb_carpark_log_ctrl;

  localparam int DEPTH = 128;
  localparam int AW    = 7;
  localparam int DW    = 40;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, ev_valid, clear, rd_req, busy_wr, busy_rd;
  logic [DW-1:0] ev_data;

  logic          rd_valid [2];
  logic [DW-1:0] rd_data  [2];
  logic [AW:0]   count    [2];
  logic          empty    [2];
  logic          full     [2];
  logic          overflow [2];
  logic          ready    [2];
  logic          ram_we   [2];
  logic [AW-1:0] ram_wa   [2];
  logic [DW-1:0] ram_wd   [2];
  logic          ram_re   [2];
  logic [AW-1:0] ram_ra   [2];
  logic [DW-1:0] ram_rdat [2];

  carpark_log_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RD_LATENCY(LAT), .OVERWRITE(0)) u_dut0 (
    .clock(clk), .reset(reset), .ev_valid(ev_valid), .ev_data(ev_data), .clear(clear),
    .rd_req(rd_req), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .count(count[0]),
    .empty(empty[0]), .full(full[0]), .overflow(overflow[0]), .ready(ready[0]),
    .ram_wr_enable(ram_we[0]), .ram_wr_addr(ram_wa[0]), .ram_wr_data(ram_wd[0]),
    .ram_rd_enable(ram_re[0]), .ram_rd_addr(ram_ra[0]), .ram_rd_data(ram_rdat[0]),
    .ram_busy_wr(busy_wr), .ram_busy_rd(busy_rd));

  carpark_log_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .RD_LATENCY(LAT), .OVERWRITE(1)) u_dut1 (
    .clock(clk), .reset(reset), .ev_valid(ev_valid), .ev_data(ev_data), .clear(clear),
    .rd_req(rd_req), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .count(count[1]),
    .empty(empty[1]), .full(full[1]), .overflow(overflow[1]), .ready(ready[1]),
    .ram_wr_enable(ram_we[1]), .ram_wr_addr(ram_wa[1]), .ram_wr_data(ram_wd[1]),
    .ram_rd_enable(ram_re[1]), .ram_rd_addr(ram_ra[1]), .ram_rd_data(ram_rdat[1]),
    .ram_busy_wr(busy_wr), .ram_busy_rd(busy_rd));

  // Dual-port RAM with LAT cycles of read latency.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ram
    logic [DW-1:0] mem  [DEPTH];
    logic [DW-1:0] pipe [LAT];
    always @(posedge clk) begin
      if (ram_we[gi]) mem[ram_wa[gi]] <= ram_wd[gi];
      pipe[0] <= ram_re[gi] ? mem[ram_ra[gi]] : '0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ram_rdat[gi] = pipe[LAT-1];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: queue of held records plus an outstanding-read countdown.
  logic [DW-1:0] mq [2][$];
  logic          m_ovf   [2];
  logic          m_rdy   [2];
  int            m_wait  [2];
  logic [DW-1:0] m_pend  [2];
  logic          m_valid [2];
  logic [DW-1:0] m_data  [2];

  task automatic tick();
    bit            pop;
    logic [DW-1:0] tmp;
    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 1'b0;
      if (reset) begin
        mq[m].delete();
        m_ovf[m] = 1'b0; m_rdy[m] = 1'b0; m_wait[m] = 0; m_data[m] = '0;
      end else if (!m_rdy[m]) begin
        if (ev_valid) m_ovf[m] = 1'b1;
        if (!busy_wr && !busy_rd) m_rdy[m] = 1'b1;
      end else if (clear) begin
        mq[m].delete();
        m_ovf[m] = 1'b0; m_wait[m] = 0;
      end else begin
        pop = (m_wait[m] == 0) && rd_req && (mq[m].size() > 0) &&
              !((mq[m].size() == DEPTH) && ev_valid);
        if (pop) begin
          m_pend[m] = mq[m].pop_front();
          m_wait[m] = LAT;
        end else if (m_wait[m] > 0) begin
          m_wait[m] = m_wait[m] - 1;
          if (m_wait[m] == 0) begin m_valid[m] = 1'b1; m_data[m] = m_pend[m]; end
        end
        if (ev_valid) begin
          if (mq[m].size() < DEPTH) mq[m].push_back(ev_data);
          else if (m == 1) begin tmp = mq[m].pop_front(); mq[m].push_back(ev_data); end
          else m_ovf[m] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    reset = 1'b1; busy_wr = 1'b1; busy_rd = 1'b1;
    ev_valid = 1'b0; ev_data = '0; clear = 1'b0; rd_req = 1'b0;
    repeat (3) tick();
    for (int m = 0; m < 2; m++) begin
      total++; if (count[m] !== '0) begin bad++; $display("FAIL reset_count inst%0d: got %0d want 0", m, count[m]); end
      total++; if (empty[m] !== 1'b1) begin bad++; $display("FAIL reset_empty inst%0d: got %0b want 1", m, empty[m]); end
      total++; if (full[m] !== 1'b0) begin bad++; $display("FAIL reset_full inst%0d: got %0b want 0", m, full[m]); end
      total++; if (overflow[m] !== 1'b0) begin bad++; $display("FAIL reset_overflow inst%0d: got %0b want 0", m, overflow[m]); end
      total++; if (rd_valid[m] !== 1'b0 || rd_data[m] !== '0) begin bad++; $display("FAIL reset_rd inst%0d: got %0b/%0h want 0/0", m, rd_valid[m], rd_data[m]); end
      total++; if (ram_we[m] !== 1'b0 || ram_re[m] !== 1'b0) begin bad++; $display("FAIL reset_ram inst%0d: got we=%0b re=%0b want 0/0", m, ram_we[m], ram_re[m]); end
    end
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      ev_valid = (c == 2); ev_data = 40'h55;
      #1;
      total++; if (ram_we[0] !== 1'b0) begin bad++; $display("FAIL busy_wr_en: got %0b want 0", ram_we[0]); end
      tick();
      for (int m = 0; m < 2; m++) begin
        total++; if (ready[m] !== 1'b0) begin bad++; $display("FAIL busy_ready inst%0d c%0d: got %0b want 0", m, c, ready[m]); end
      end
    end
    ev_valid = 1'b0; busy_wr = 1'b0; busy_rd = 1'b0;
    tick();
    for (int m = 0; m < 2; m++) begin
      total++; if (ready[m] !== 1'b1) begin bad++; $display("FAIL ready_rise inst%0d: got %0b want 1", m, ready[m]); end
      total++; if (overflow[m] !== 1'b1 || count[m] !== '0) begin bad++; $display("FAIL init_drop inst%0d: got ovf=%0b cnt=%0d want 1/0", m, overflow[m], count[m]); end
    end
    clear = 1'b1; tick(); clear = 1'b0;
    total++; if (overflow[0] !== 1'b0) begin bad++; $display("FAIL clear_ovf: got %0b want 0", overflow[0]); end
  endtask

  task automatic test_order();
    int issue_q[$];
    int got = 0;
    int t0;
    for (int k = 1; k <= 3; k++) begin ev_valid = 1'b1; ev_data = DW'(k); tick(); end
    ev_valid = 1'b0; rd_req = 1'b1;
    for (int c = 0; c < 40 && got < 3; c++) begin
      #1;
      if (ram_re[0]) issue_q.push_back(cyc);
      tick();
      if (rd_valid[0]) begin
        total++; if (rd_data[0] !== DW'(got + 1)) begin bad++; $display("FAIL order_data: got %0h want %0h", rd_data[0], got + 1); end
        t0 = (issue_q.size() > 0) ? issue_q.pop_front() : -100;
        total++; if (cyc - t0 != LAT + 1) begin bad++; $display("FAIL order_latency: got %0d want %0d", cyc - t0, LAT + 1); end
        got++;
      end
    end
    rd_req = 1'b0;
    total++; if (got != 3) begin bad++; $display("FAIL order_timeout: got %0d pops want 3", got); end
    total++; if (empty[0] !== 1'b1 || count[0] !== '0) begin bad++; $display("FAIL order_empty: got e=%0b c=%0d want 1/0", empty[0], count[0]); end
  endtask

  task automatic test_fill();
    int n [2];
    n[0] = 0; n[1] = 0;
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 0; k < 130; k++) begin ev_valid = 1'b1; ev_data = DW'(k); tick(); end
    ev_valid = 1'b0;
    for (int m = 0; m < 2; m++) begin
      total++; if (count[m] !== 8'd128 || full[m] !== 1'b1) begin bad++; $display("FAIL fill_full inst%0d: got c=%0d f=%0b want 128/1", m, count[m], full[m]); end
      total++; if (overflow[m] !== (m == 0)) begin bad++; $display("FAIL fill_ovf inst%0d: got %0b want %0b", m, overflow[m], m == 0); end
    end
    rd_req = 1'b1;
    for (int c = 0; c < 1000 && (n[0] < 128 || n[1] < 128); c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if (rd_valid[m]) begin
          total++; if (rd_data[m] !== DW'(n[m] + 2 * m)) begin bad++; $display("FAIL fill_pop inst%0d #%0d: got %0h want %0h", m, n[m], rd_data[m], n[m] + 2 * m); end
          n[m]++;
        end
      end
    end
    rd_req = 1'b0;
    for (int m = 0; m < 2; m++) begin
      total++; if (n[m] != 128 || empty[m] !== 1'b1) begin bad++; $display("FAIL fill_drain inst%0d: got pops=%0d e=%0b want 128/1", m, n[m], empty[m]); end
    end
  endtask

  task automatic test_collision();
    bit seen = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 0; k < 128; k++) begin ev_valid = 1'b1; ev_data = DW'(256 + k); tick(); end
    ev_data = 40'h999; rd_req = 1'b1;
    #1;
    total++; if (ram_re[0] !== 1'b0 || ram_re[1] !== 1'b0) begin bad++; $display("FAIL coll_rd_en: got %0b/%0b want 0/0", ram_re[0], ram_re[1]); end
    total++; if (ram_we[0] !== 1'b0 || ram_we[1] !== 1'b1) begin bad++; $display("FAIL coll_wr_en: got %0b/%0b want 0/1", ram_we[0], ram_we[1]); end
    tick();
    ev_valid = 1'b0;
    for (int m = 0; m < 2; m++) begin
      total++; if (count[m] !== 8'd128) begin bad++; $display("FAIL coll_count inst%0d: got %0d want 128", m, count[m]); end
    end
    #1;
    total++; if (ram_re[0] !== 1'b1 || ram_re[1] !== 1'b1) begin bad++; $display("FAIL coll_retry: got %0b/%0b want 1/1", ram_re[0], ram_re[1]); end
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (rd_valid[0] || rd_valid[1]) begin
        seen = 1'b1; rd_req = 1'b0;
        total++; if (rd_data[0] !== 40'h100) begin bad++; $display("FAIL coll_data0: got %0h want 100", rd_data[0]); end
        total++; if (rd_data[1] !== 40'h101) begin bad++; $display("FAIL coll_data1: got %0h want 101", rd_data[1]); end
      end
    end
    rd_req = 1'b0;
    total++; if (!seen) begin bad++; $display("FAIL coll_timeout: got no rd_valid want 1"); end
    total++; if (count[0] !== 8'd127 || count[1] !== 8'd127) begin bad++; $display("FAIL coll_after: got %0d/%0d want 127/127", count[0], count[1]); end
  endtask

  task automatic test_clear_rdwait();
    clear = 1'b1; tick(); clear = 1'b0;
    for (int k = 0; k < 6; k++) begin ev_valid = 1'b1; ev_data = DW'(k + 10); tick(); end
    ev_valid = 1'b0; rd_req = 1'b1;
    #1;
    total++; if (ram_re[0] !== 1'b1 || ram_ra[0] !== '0) begin bad++; $display("FAIL clr_issue: got re=%0b a=%0d want 1/0", ram_re[0], ram_ra[0]); end
    tick();
    rd_req = 1'b0;
    total++; if (count[0] !== 8'd5) begin bad++; $display("FAIL clr_pre_count: got %0d want 5", count[0]); end
    clear = 1'b1; tick(); clear = 1'b0;
    total++; if (count[0] !== '0 || empty[0] !== 1'b1) begin bad++; $display("FAIL clr_count: got c=%0d e=%0b want 0/1", count[0], empty[0]); end
    for (int c = 0; c < LAT + 3; c++) begin
      total++; if (rd_valid[0] !== 1'b0) begin bad++; $display("FAIL clr_no_valid c%0d: got %0b want 0", c, rd_valid[0]); end
      tick();
    end
    ev_valid = 1'b1; ev_data = 40'hABC;
    #1;
    total++; if (ram_we[0] !== 1'b1 || ram_wa[0] !== '0) begin bad++; $display("FAIL clr_wr_addr: got we=%0b a=%0d want 1/0", ram_we[0], ram_wa[0]); end
    tick();
    ev_valid = 1'b0;
  endtask

  task automatic test_random();
    int wr_pct, rd_pct;
    for (int i = 0; i < 2400; i++) begin
      wr_pct = (i < 800) ? 80 : (i < 1600) ? 20 : 55;
      rd_pct = (i < 800) ? 50 : 95;
      ev_valid = ($urandom_range(0, 99) < wr_pct);
      ev_data  = {$urandom, $urandom} & {DW{1'b1}};
      rd_req   = ($urandom_range(0, 99) < rd_pct);
      clear    = ($urandom_range(0, 299) == 0);
      reset    = (i >= 2000 && i < 2002);
      busy_wr  = (i >= 2002 && i < 2005);
      busy_rd  = (i >= 2001 && i < 2004);
      tick();
      for (int m = 0; m < 2; m++) begin
        total++;
        if (int'(count[m]) != mq[m].size() || empty[m] !== (mq[m].size() == 0) ||
            full[m] !== (mq[m].size() == DEPTH) || overflow[m] !== m_ovf[m] || ready[m] !== m_rdy[m]) begin
          bad++;
          $display("FAIL rand_state inst%0d cyc%0d: got c=%0d e=%0b f=%0b o=%0b r=%0b want c=%0d o=%0b r=%0b",
                   m, cyc, count[m], empty[m], full[m], overflow[m], ready[m], mq[m].size(), m_ovf[m], m_rdy[m]);
        end
        total++;
        if (rd_valid[m] !== m_valid[m] || rd_data[m] !== m_data[m]) begin
          bad++;
          $display("FAIL rand_read inst%0d cyc%0d: got v=%0b d=%0h want v=%0b d=%0h",
                   m, cyc, rd_valid[m], rd_data[m], m_valid[m], m_data[m]);
        end
      end
    end
    ev_valid = 1'b0; rd_req = 1'b0; clear = 1'b0; reset = 1'b0; busy_wr = 1'b0; busy_rd = 1'b0;
  endtask

  initial begin
    test_reset();
    test_order();
    test_fill();
    test_collision();
    test_clear_rdwait();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
